// File: rtl/alu_operand_entry_if.sv
// Operation bus from the operand-entry front end to the ALU wrapper:
// two sign-extended operands and an opcode, offered under valid/ready.
interface alu_operand_entry_if;
   logic [31:0] portA;
   logic [31:0] portB;
   logic [3:0]  aluop;
   logic        op_valid;
   logic        op_ready;

   modport master (
      output portA,
      output portB,
      output aluop,
      output op_valid,
      input  op_ready
   );

   modport slave (
      input  portA,
      input  portB,
      input  aluop,
      input  op_valid,
      output op_ready
   );
endinterface

// File: rtl/alu_operand_entry.sv
// Board input front end for the ALU harness: synchronizes and debounces the
// active-low push-buttons, turns presses into one-cycle events, and walks a
// capture sequence (A, B, opcode) before offering the operation on the bus.
module alu_operand_entry #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int KEYS            = 4
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [KEYS-1:0]     key_n,
   input  logic [17:0]         sw,
   alu_operand_entry_if.master bus,
   output logic [1:0]          state_dbg,
   output logic [KEYS-1:0]     key_evt
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      GET_A  = 2'd0,
      GET_B  = 2'd1,
      GET_OP = 2'd2,
      ISSUE  = 2'd3
   } state_t;

   // Key synchronizer, debounced levels and press events.
   logic [KEYS-1:0]  r_key_s1;
   logic [KEYS-1:0]  r_key_s2;
   logic [KEYS-1:0]  r_key_deb;
   logic [KEYS-1:0]  r_key_evt;
   logic [CNT_W-1:0] r_cnt [KEYS];

   // Switch synchronizer.
   logic [17:0] r_sw_s1;
   logic [17:0] r_sw_s2;

   // Sequencer state and captured operation.
   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_port_a;
   logic [31:0] r_port_b;
   logic [3:0]  r_aluop;
   logic        r_op_valid;
   logic        w_valid_nxt;
   logic        w_ld_a;
   logic        w_ld_b;
   logic        w_ld_op;

   logic        w_cap;
   logic        w_abt;
   logic [31:0] w_value;
   logic        w_unused;

   assign w_cap    = r_key_evt[0];
   assign w_abt    = r_key_evt[1];
   assign w_value  = {{16{r_sw_s2[16]}}, r_sw_s2[15:0]};
   assign w_unused = r_sw_s2[17];

   // Two-flop synchronizers for keys and switches; keys idle at released (1).
   // NOTE: every clocked process uses non-blocking assignments so that all
   // flops sample the pre-edge values and the two sync stages stay distinct.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_key_s1 <= '1;
         r_key_s2 <= '1;
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
      end else begin
         r_key_s1 <= key_n;
         r_key_s2 <= r_key_s1;
         r_sw_s1  <= sw;
         r_sw_s2  <= r_sw_s1;
      end
   end

   // Per-key debounce: count consecutive samples that differ from the
   // accepted level; flip after DEBOUNCE_CYCLES of them and flag a press.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_key_deb <= '1;
         r_key_evt <= '0;
         for (int i = 0; i < KEYS; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_key_evt <= '0;
         for (int i = 0; i < KEYS; i++) begin
            if (r_key_s2[i] == r_key_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_cnt[i]     <= '0;
               r_key_deb[i] <= r_key_s2[i];
               r_key_evt[i] <= ~r_key_s2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Sequencer state register and offered-valid flag.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state    <= GET_A;
         r_op_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_op_valid <= w_valid_nxt;
      end
   end

   // Next-state logic: a completing transfer beats abort, abort beats capture.
   // NOTE: every output of this block is defaulted first so no path through
   // the case leaves a signal unassigned and infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = r_op_valid;
      w_ld_a      = 1'b0;
      w_ld_b      = 1'b0;
      w_ld_op     = 1'b0;
      if (r_state == ISSUE && r_op_valid && bus.op_ready) begin
         w_state_nxt = GET_A;
         w_valid_nxt = 1'b0;
      end else if (w_abt) begin
         w_state_nxt = GET_A;
         w_valid_nxt = 1'b0;
      end else if (w_cap) begin
         case (r_state)
            GET_A: begin
               w_ld_a      = 1'b1;
               w_state_nxt = GET_B;
            end
            GET_B: begin
               w_ld_b      = 1'b1;
               w_state_nxt = GET_OP;
            end
            GET_OP: begin
               w_ld_op     = 1'b1;
               w_state_nxt = ISSUE;
               w_valid_nxt = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Captured operands and opcode; each changes only on its own capture edge.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_port_a <= '0;
         r_port_b <= '0;
         r_aluop  <= '0;
      end else begin
         if (w_ld_a)  r_port_a <= w_value;
         if (w_ld_b)  r_port_b <= w_value;
         if (w_ld_op) r_aluop  <= r_sw_s2[3:0];
      end
   end

   assign bus.portA    = r_port_a;
   assign bus.portB    = r_port_b;
   assign bus.aluop    = r_aluop;
   assign bus.op_valid = r_op_valid;
   assign state_dbg    = r_state;
   assign key_evt      = r_key_evt;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed bench for alu_operand_entry: table of full capture sequences plus
// hand-written sequences for bounce, backpressure, abort and reset corners.
module tb_alu_operand_entry;

   localparam int DEB  = 16;
   localparam int KEYS = 4;

   logic            clk;
   logic            rst_n;
   logic [KEYS-1:0] key_n;
   logic [17:0]     sw;
   logic [1:0]      state_dbg;
   logic [KEYS-1:0] key_evt;

   alu_operand_entry_if bus ();

   alu_operand_entry #(
      .DEBOUNCE_CYCLES(DEB),
      .KEYS           (KEYS)
   ) dut (
      .CLK      (clk),
      .nRST     (rst_n),
      .key_n    (key_n),
      .sw       (sw),
      .bus      (bus),
      .state_dbg(state_dbg),
      .key_evt  (key_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int valid_cycles = 0;
   int xfers = 0;

   typedef struct {
      logic [17:0] sw_a;
      logic [17:0] sw_b;
      logic [17:0] sw_op;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [3:0]  exp_op;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Hold the masked keys low for 24 cycles then released for 24, sampling
   // outputs at each falling edge before driving.
   task automatic press(input logic [KEYS-1:0] mask);
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         if (bus.op_valid) valid_cycles++;
         if (bus.op_valid && bus.op_ready) xfers++;
         key_n = (c < 24) ? ~mask : '1;
      end
   endtask

   task automatic load_op(input logic [17:0] a, input logic [17:0] b, input logic [17:0] op);
      sw = a;  press(4'b0001);
      sw = b;  press(4'b0001);
      sw = op; press(4'b0001);
   endtask

   initial begin
      int ev;
      int pos;
      int v0;
      int x0;

      vecs[0] = '{18'h1_0005, 18'h0_0003, 18'h0_0002, 32'hFFFF_0005, 32'h0000_0003, 4'h2};
      vecs[1] = '{18'h0_7FFF, 18'h1_FFFF, 18'h0_000F, 32'h0000_7FFF, 32'hFFFF_FFFF, 4'hF};
      vecs[2] = '{18'h1_8000, 18'h0_0000, 18'h0_0000, 32'hFFFF_8000, 32'h0000_0000, 4'h0};
      vecs[3] = '{18'h2_00A5, 18'h1_0001, 18'h3_FFF9, 32'h0000_00A5, 32'hFFFF_0001, 4'h9};

      rst_n = 1'b0;
      key_n = '1;
      sw = '0;
      bus.op_ready = 1'b0;
      #23;
      check("rst_portA", bus.portA, 32'h0);
      check("rst_portB", bus.portB, 32'h0);
      check("rst_aluop", 32'(bus.aluop), 32'h0);
      check("rst_valid", 32'(bus.op_valid), 32'h0);
      check("rst_state", 32'(state_dbg), 32'h0);
      check("rst_evt", 32'(key_evt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Bounce: a 10-cycle glitch is ignored, a long press gives one event.
      ev = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (key_evt[0]) ev++;
         key_n[0] = (c < 10) ? 1'b0 : 1'b1;
      end
      repeat (5) begin
         @(negedge clk);
         if (key_evt[0]) ev++;
      end
      check("glitch_no_evt", 32'(ev), 32'd0);
      check("glitch_state", 32'(state_dbg), 32'd0);
      ev = 0;
      pos = -1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (key_evt[0]) begin
            ev++;
            pos = c;
         end
         key_n[0] = (c < 40) ? 1'b0 : 1'b1;
      end
      check("bounce_evt_count", 32'(ev), 32'd1);
      check("bounce_evt_latency", 32'(pos), 32'd18);
      check("bounce_state_getb", 32'(state_dbg), 32'd1);
      press(4'b0010);
      check("bounce_abort_state", 32'(state_dbg), 32'd0);

      // Table of full sequences with the ALU side always ready.
      bus.op_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         valid_cycles = 0;
         xfers = 0;
         load_op(vecs[i].sw_a, vecs[i].sw_b, vecs[i].sw_op);
         check($sformatf("vec%0d_portA", i), bus.portA, vecs[i].exp_a);
         check($sformatf("vec%0d_portB", i), bus.portB, vecs[i].exp_b);
         check($sformatf("vec%0d_aluop", i), 32'(bus.aluop), 32'(vecs[i].exp_op));
         check($sformatf("vec%0d_valid_cycles", i), 32'(valid_cycles), 32'd1);
         check($sformatf("vec%0d_xfers", i), 32'(xfers), 32'd1);
         check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'd0);
      end

      // Backpressure: extra capture presses are ignored while waiting.
      bus.op_ready = 1'b0;
      valid_cycles = 0;
      xfers = 0;
      load_op(18'h0_1234, 18'h1_8000, 18'h0_0005);
      sw = 18'h0_0ABC;
      press(4'b0001);
      press(4'b0001);
      check("bp_valid", 32'(bus.op_valid), 32'd1);
      check("bp_state", 32'(state_dbg), 32'd3);
      check("bp_portA", bus.portA, 32'h0000_1234);
      check("bp_portB", bus.portB, 32'hFFFF_8000);
      check("bp_aluop", 32'(bus.aluop), 32'h5);
      check("bp_no_xfer", 32'(xfers), 32'd0);
      bus.op_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (bus.op_valid && bus.op_ready) xfers++;
         @(negedge clk);
      end
      check("bp_one_xfer", 32'(xfers), 32'd1);
      check("bp_done_state", 32'(state_dbg), 32'd0);
      check("bp_done_valid", 32'(bus.op_valid), 32'd0);

      // Abort in GET_OP: nothing offered, operands kept.
      bus.op_ready = 1'b1;
      valid_cycles = 0;
      sw = 18'h0_0007; press(4'b0001);
      sw = 18'h0_0009; press(4'b0001);
      check("abt_in_getop", 32'(state_dbg), 32'd2);
      press(4'b0010);
      check("abt_state", 32'(state_dbg), 32'd0);
      check("abt_no_valid", 32'(valid_cycles), 32'd0);
      check("abt_portA", bus.portA, 32'h0000_0007);
      check("abt_portB", bus.portB, 32'h0000_0009);

      // Capture and abort together in GET_B: abort wins, portB kept.
      sw = 18'h0_0011; press(4'b0001);
      check("sim_in_getb", 32'(state_dbg), 32'd1);
      sw = 18'h0_0022; press(4'b0011);
      check("sim_state", 32'(state_dbg), 32'd0);
      check("sim_portA", bus.portA, 32'h0000_0011);
      check("sim_portB", bus.portB, 32'h0000_0009);

      // Abort in ISSUE on the same edge as op_ready: counts as a transfer.
      bus.op_ready = 1'b0;
      xfers = 0;
      load_op(18'h0_0031, 18'h0_0032, 18'h0_0003);
      check("ai_in_issue", 32'(state_dbg), 32'd3);
      v0 = 0;
      x0 = 0;
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         if (key_evt[1]) begin
            v0++;
            bus.op_ready = 1'b1;
         end
         if (bus.op_valid && bus.op_ready) x0++;
         key_n = (c < 24) ? 4'b1101 : 4'b1111;
      end
      bus.op_ready = 1'b0;
      check("ai_abt_evt", 32'(v0), 32'd1);
      check("ai_xfers", 32'(x0), 32'd1);
      check("ai_state", 32'(state_dbg), 32'd0);
      check("ai_aluop", 32'(bus.aluop), 32'h3);

      // Asynchronous reset while an operation is offered.
      load_op(18'h0_0005, 18'h0_0006, 18'h0_0001);
      check("rr_in_issue", 32'(state_dbg), 32'd3);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rr_valid", 32'(bus.op_valid), 32'd0);
      check("rr_portA", bus.portA, 32'h0);
      check("rr_portB", bus.portB, 32'h0);
      check("rr_aluop", 32'(bus.aluop), 32'h0);
      check("rr_state", 32'(state_dbg), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.op_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("rr_after_valid", 32'(bus.op_valid), 32'd0);
      check("rr_after_state", 32'(state_dbg), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_operand_entry.md
Name: alu_operand_entry

Overview:
- Input front end for the board-level ALU harness: turns raw push-buttons and slide switches into clean, sequenced ALU operations.
- Synchronizes and debounces the active-low keys and converts presses into one-cycle events.
- Walks a capture sequence (operand A, operand B, opcode) and presents the finished operation to the ALU side over a valid/ready handshake.
- Sits between the board pins and the ALU wrapper, which keeps ownership of the seven-segment result display.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a new key level (board build overrides to 500000).
- KEYS, 4, number of push-buttons handled.

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- key_n  input  KEYS  raw push-buttons, 0 = pressed; key_n[0] = capture/advance, key_n[1] = abort, others are debounced but unused
- sw  input  18  raw slide switches; sw[16] = sign, sw[15:0] = magnitude bits, sw[3:0] = opcode in GET_OP
- portA  output  32  captured operand A
- portB  output  32  captured operand B
- aluop  output  4  captured opcode
- op_valid  output  1  operation offered to the ALU side
- op_ready  input  1  ALU side accepts the operation
- state_dbg  output  2  current FSM state encoding, for LEDs
- key_evt  output  KEYS  one-cycle press pulses, for debug and verification

Behaviour:
- Reset (async, nRST=0): portA=0, portB=0, aluop=0, op_valid=0, key_evt=0, state=GET_A (state_dbg=0).
  - Synchronizer flops and debounced levels reset to 1 (released); debounce counters reset to 0.
- Synchronizer: two flops per key; sw is also synchronized with two flops. Captures always use the synchronized sw.
- Debounce, per key:
  - Counter clears whenever the synchronized sample equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A pulse shorter than DEBOUNCE_CYCLES never changes the level.
- key_evt[i]: high for exactly one cycle on the edge where the debounced level of key i goes 1->0. Release produces no event.
  - Latency: key_evt is high DEBOUNCE_CYCLES+2 cycles after the raw level changes and is held stable.
- Sign extension: value = {16{sw_s[16]}, sw_s[15:0]}.
- FSM, with cap = key_evt[0] and abt = key_evt[1]:
  - GET_A (0): on cap, portA <= value, go to GET_B.
  - GET_B (1): on cap, portB <= value, go to GET_OP.
  - GET_OP (2): on cap, aluop <= sw_s[3:0], go to ISSUE; op_valid becomes 1 on the same edge.
  - ISSUE (3): op_valid=1. When op_valid and op_ready are both high on a clock edge, the transfer completes: op_valid <= 0, go to GET_A. cap is ignored in ISSUE.
  - abt in any state except a completing transfer: op_valid <= 0, go to GET_A. Captured registers are not cleared.
- Simultaneous events:
  - cap and abt in the same cycle: abort wins.
  - ISSUE with op_ready=1 and abt in the same cycle: the transfer completes (counts as accepted), then GET_A.
- Stability: portA, portB and aluop change only on their capture edge. They are stable for the whole time op_valid=1.
- op_ready is ignored outside ISSUE.
- Reset asserted mid-sequence or mid-handshake: all outputs return to reset values immediately (async) and any pending op is discarded.

Test Plan:
- Reset with nRST=0 while in ISSUE -> op_valid=0, portA=portB=0, aluop=0, state_dbg=0 with no clock edge needed.
- Bounce: key_n[0] low for 10 cycles, high, then low for 40 cycles (DEBOUNCE_CYCLES=16) -> exactly one key_evt[0] pulse, 18 cycles after the second falling edge; no event from the 10-cycle glitch.
- Full sequence with op_ready=1:
  - Stimulus: capture sw=0x1_0005, then sw=0x0_0003, then sw[3:0]=0x2.
  - Required: portA=0xFFFF0005, portB=0x00000003, aluop=2, op_valid high for exactly 1 cycle, state returns to 0.
- Backpressure: op_ready=0 for 20 cycles in ISSUE with extra capture presses -> op_valid stays 1, portA/portB/aluop unchanged, state_dbg=3. Then op_ready=1 -> one transfer, state 0.
- Abort in GET_OP after A=0x00000007 and B=0x00000009 -> state_dbg=0, op_valid never asserted, portA still 0x00000007.
- Simultaneous press of keys 0 and 1 in GET_B -> state 0, portB unchanged. Abort in ISSUE coinciding with op_ready=1 -> one accepted transfer, state 0.
